// File: rtl/switch_allocator_pkg.sv
// Shared router types for the switch allocator: port/VC sizing, port and flit-label
// encodings, and the per-output wormhole lock record.
package switch_allocator_pkg;

    localparam int in_Port_Cnt  = 5;
    localparam int out_Port_Cnt = in_Port_Cnt;
    localparam int vc_Num       = 2;
    localparam int in_port_Size = 3;
    localparam int VC_Size      = 1;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } inout_Port;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_Data_Label;

    typedef struct packed {
        logic                    valid;
        logic [in_port_Size-1:0] in_Id;
        logic [VC_Size-1:0]      vc_Id;
    } out_Lock;

    // HEAD and HEADTAIL both open a packet and need an unlocked output.
    function automatic logic is_head(input flit_Data_Label lbl);
        return (lbl == HEAD) || (lbl == HEADTAIL);
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input VC buffers, the crossbar and the allocator.
interface switch_allocator_if
    import switch_allocator_pkg::*;
#(
    parameter int N_PORTS = in_Port_Cnt,
    parameter int N_VC    = vc_Num
);

    logic [N_PORTS*N_VC-1:0]              req;
    logic [N_PORTS*N_VC*in_port_Size-1:0] req_port;
    logic [N_PORTS*N_VC*2-1:0]            req_label;
    logic [N_PORTS-1:0]                   out_ready;
    logic [N_PORTS-1:0]                   gnt_valid;
    logic [N_PORTS*VC_Size-1:0]           gnt_vc;
    logic [N_PORTS-1:0]                   xbar_valid;
    logic [N_PORTS*in_port_Size-1:0]      xbar_sel;
    logic                                 err;

    modport master (
        output req, req_port, req_label, out_ready,
        input  gnt_valid, gnt_vc, xbar_valid, xbar_sel, err
    );

    modport slave (
        input  req, req_port, req_label, out_ready,
        output gnt_valid, gnt_vc, xbar_valid, xbar_sel, err
    );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the held pointer; the pointer
// moves just past the winner only when the grant is actually used (update).
module rr_arbiter
    import switch_allocator_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         update,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win;
    logic          found;

    // First pass covers indices at/after the pointer, second pass wraps around.
    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (PW'(j) >= ptr_q)) begin
                gnt[j] = 1'b1;
                win    = PW'(j);
                found  = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j]) begin
                gnt[j] = 1'b1;
                win    = PW'(j);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update && found) begin
            ptr_d = (win == PW'(N - 1)) ? '0 : win + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator with per-output wormhole locks; grants are
// combinational from the current requests and the registered pointers/locks.
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int N_PORTS = in_Port_Cnt,
    parameter int N_VC    = vc_Num
) (
    input logic               clk,
    input logic               rst,
    switch_allocator_if.slave sa
);

    out_Lock                 lock_q [N_PORTS];
    out_Lock                 lock_d [N_PORTS];
    logic                    err_q, err_d;

    logic [N_VC-1:0]         elig     [N_PORTS];
    logic [N_VC-1:0]         s1_gnt   [N_PORTS];
    logic [N_PORTS-1:0]      s1_valid;
    logic [VC_Size-1:0]      s1_vc    [N_PORTS];
    logic [in_port_Size-1:0] s1_port  [N_PORTS];
    flit_Data_Label          s1_label [N_PORTS];
    logic [N_PORTS-1:0]      s2_req   [N_PORTS];
    logic [N_PORTS-1:0]      s2_gnt   [N_PORTS];
    logic [N_PORTS-1:0]      gnt_valid_w, xbar_valid_w;
    logic [in_port_Size-1:0] sel_w    [N_PORTS];

    logic [in_port_Size-1:0] vc_port;
    flit_Data_Label          vc_label;
    out_Lock                 vc_lock;
    logic                    vc_owner;

    // VC eligibility and protocol-error detection against the current locks.
    always_comb begin
        err_d    = err_q;
        vc_port  = '0;
        vc_label = BODY;
        vc_lock  = '0;
        vc_owner = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            elig[i] = '0;
            for (int v = 0; v < N_VC; v++) begin
                vc_port  = sa.req_port[(i*N_VC+v)*in_port_Size +: in_port_Size];
                vc_label = flit_Data_Label'(sa.req_label[(i*N_VC+v)*2 +: 2]);
                if (sa.req[i*N_VC+v]) begin
                    if (vc_port >= in_port_Size'(N_PORTS)) begin
                        err_d = 1'b1;
                    end else begin
                        vc_lock  = lock_q[vc_port];
                        vc_owner = vc_lock.valid && (vc_lock.in_Id == in_port_Size'(i))
                                   && (vc_lock.vc_Id == VC_Size'(v));
                        if (!vc_lock.valid && !is_head(vc_label)) err_d = 1'b1;
                        if (vc_owner && is_head(vc_label))        err_d = 1'b1;
                        if (sa.out_ready[vc_port] &&
                            ((!vc_lock.valid && is_head(vc_label)) ||
                             (vc_owner && !is_head(vc_label)))) begin
                            elig[i][v] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_in_arb
        rr_arbiter #(.N(N_VC)) u_vc_arb (
            .clk    (clk),
            .rst    (rst),
            .req    (elig[gi]),
            .update (gnt_valid_w[gi]),
            .gnt    (s1_gnt[gi])
        );
    end

    // Stage 1 winner per input, then fan its request out to the target output.
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            s1_valid[i] = |s1_gnt[i];
            s1_vc[i]    = '0;
            s1_port[i]  = '0;
            s1_label[i] = BODY;
            for (int v = 0; v < N_VC; v++) begin
                if (s1_gnt[i][v]) begin
                    s1_vc[i]    = VC_Size'(v);
                    s1_port[i]  = sa.req_port[(i*N_VC+v)*in_port_Size +: in_port_Size];
                    s1_label[i] = flit_Data_Label'(sa.req_label[(i*N_VC+v)*2 +: 2]);
                end
            end
        end
        for (int o = 0; o < N_PORTS; o++) begin
            for (int i = 0; i < N_PORTS; i++) begin
                s2_req[o][i] = s1_valid[i] && (s1_port[i] == in_port_Size'(o));
            end
        end
    end

    for (genvar go = 0; go < N_PORTS; go++) begin : g_out_arb
        rr_arbiter #(.N(N_PORTS)) u_in_arb (
            .clk    (clk),
            .rst    (rst),
            .req    (s2_req[go]),
            .update (xbar_valid_w[go]),
            .gnt    (s2_gnt[go])
        );
    end

    // Stage 2 result: crossbar selects, per-input grants and lock bookkeeping.
    always_comb begin
        gnt_valid_w = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            xbar_valid_w[o] = |s2_gnt[o];
            sel_w[o]        = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                if (s2_gnt[o][i]) begin
                    sel_w[o]       = in_port_Size'(i);
                    gnt_valid_w[i] = 1'b1;
                end
            end
            lock_d[o] = lock_q[o];
            if (xbar_valid_w[o]) begin
                case (s1_label[sel_w[o]])
                    HEAD:    lock_d[o] = '{valid: 1'b1, in_Id: sel_w[o], vc_Id: s1_vc[sel_w[o]]};
                    TAIL:    lock_d[o] = '0;
                    default: lock_d[o] = lock_q[o];
                endcase
            end
        end
    end

    always_comb begin
        sa.gnt_vc   = '0;
        sa.xbar_sel = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (gnt_valid_w[i] && !rst) sa.gnt_vc[i*VC_Size +: VC_Size] = s1_vc[i];
            if (xbar_valid_w[i] && !rst) sa.xbar_sel[i*in_port_Size +: in_port_Size] = sel_w[i];
        end
    end

    assign sa.gnt_valid  = rst ? '0 : gnt_valid_w;
    assign sa.xbar_valid = rst ? '0 : xbar_valid_w;
    assign sa.err        = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < N_PORTS; o++) lock_q[o] <= '0;
            err_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-cycle switch allocator for the 5-port (LOCAL/NORTH/EAST/SOUTH/WEST), 2-VC wormhole router built on params_noc.
- Separable input-first round-robin allocation:
  - stage 1 picks one VC per input port;
  - stage 2 picks one input per output port.
- Holds each output locked to one (input, VC) from HEAD to TAIL.
- Drives crossbar select and per-input-VC flit dequeue.

Parameters:
- N_PORTS, in_Port_Cnt (5), number of input ports and number of output ports.
- N_VC, vc_Num (2), virtual channels per input port.

Ports:
- clk  in  1  router clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_PORTS*N_VC  VC [i*N_VC+v] has a flit at buffer head.
- req_port  in  N_PORTS*N_VC*3  requested output port per VC (inout_Port encoding).
- req_label  in  N_PORTS*N_VC*2  flit_Data_Label of that head flit.
- out_ready  in  N_PORTS  downstream of output o can accept a flit this cycle.
- gnt_valid  out  N_PORTS  input i wins this cycle.
- gnt_vc  out  N_PORTS*VC_Size  winning VC of input i.
- xbar_valid  out  N_PORTS  output o carries a flit this cycle.
- xbar_sel  out  N_PORTS*in_port_Size  input driving output o.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Combinational grant path from current inputs plus registered state; zero-cycle allocation latency. State updates on posedge clk.
- Registered state:
  - rr_in[i] (VC pointer per input).
  - rr_out[o] (input pointer per output).
  - lock_v[o], lock_in[o], lock_vc[o].
  - err.
- Reset (async, any time, including mid-packet):
  - all pointers 0, all locks cleared, err 0.
  - While rst is high, gnt_valid, xbar_valid, gnt_vc, xbar_sel are forced to 0.
- Eligibility of VC (i,v), all of the following must hold:
  - req is set;
  - req_port ≤ 4;
  - out_ready[o] is set, where o = req_port;
  - either !lock_v[o] with label HEAD/HEADTAIL, or lock_v[o] with lock_in[o]==i and lock_vc[o]==v with label BODY/TAIL.
- Stage 1: per input, round-robin among eligible VCs, starting search at rr_in[i].
- Stage 2: per output, round-robin among inputs whose stage-1 winner targets it, starting at rr_out[o].
- Stage-1 losers of stage 2 are not retried in the same cycle.
- On a granted flit at output o from input i:
  - gnt_valid[i]=1, gnt_vc[i]=v, xbar_valid[o]=1, xbar_sel[o]=i.
- On a granted flit, at the next edge:
  - rr_in[i] ← (v+1) mod N_VC;
  - rr_out[o] ← (i+1) mod N_PORTS;
  - label HEAD: set lock (o, i, v);
  - label TAIL: clear lock;
  - label BODY: lock unchanged;
  - label HEADTAIL: no lock change.
- Pointers update only on a grant; a denied request leaves them unchanged.
- Locked output with its owner not requesting or not eligible: output idle; lock held indefinitely.
- out_ready[o]=0: no grant to o; lock and pointers held.
- Errors: err sets on the next edge and stays set until rst. Setting conditions:
  - a requesting VC with req_port > 4;
  - BODY/TAIL requesting an unlocked output;
  - HEAD/HEADTAIL requesting an output locked to itself.
- Offending requests are never granted.
- Invariants:
  - each input granted at most once per cycle;
  - each output granted at most once per cycle;
  - xbar_sel is consistent with gnt_vc.
- Simultaneous TAIL grant and a new HEAD for the same output in the same cycle: impossible. The HEAD is ineligible while the lock is set; the HEAD may win the following cycle.

Decomposition:
- params_noc additions: inout_Port already supplies port encoding.
- Add to params_noc:
  - localparam out_Port_Cnt = in_Port_Cnt;
  - typedef out_Lock struct packed {valid, in_Id[in_port_Size], vc_Id[VC_Size]}.
- One sub-module: rr_arbiter, parameter N.
  - Ports: clk, rst, req[N], update, gnt[N] one-hot.
  - Holds its own pointer; the pointer advances past the grant when update is asserted.
  - Instantiated N_PORTS times with N=N_VC and N_PORTS times with N=N_PORTS.
  - Lock registers and eligibility logic stay in switch_allocator.

Test Plan:
- Reset/idle:
  - Stimulus: rst pulsed mid-cycle with reqs active.
  - Required: outputs 0 immediately; after release with no req, all grants 0; err=0.
- Single HEADTAIL:
  - Stimulus: input WEST VC1 → EAST, out_ready all 1.
  - Required: same cycle gnt_valid[4]=1, gnt_vc[4]=1, xbar_valid[2]=1, xbar_sel[2]=4; no lock afterwards.
- Output contention:
  - Stimulus: LOCAL, NORTH, SOUTH all send HEADTAIL → EAST every cycle.
  - Required: grants rotate 0,1,3,0,1,3 over 6 cycles.
- Wormhole lock:
  - Stimulus: NORTH VC0 sends HEAD, BODY, BODY, TAIL → SOUTH while WEST VC0 requests HEAD → SOUTH throughout.
  - Required: NORTH owns SOUTH for 4 consecutive cycles; WEST granted on cycle 5.
- VC fairness and backpressure:
  - Stimulus: EAST VC0 → LOCAL and EAST VC1 → NORTH, both HEADTAIL, with out_ready[LOCAL]=0 for 2 cycles.
  - Required: VC1 granted while LOCAL is blocked; afterwards VC0 and VC1 alternate.
- Errors:
  - Stimulus: BODY to an unlocked output; req_port=6.
  - Required: never granted; err=1 next cycle and stays set until rst.
